// File: rtl/mem_wb_writeback.sv
// -----------------------------------------------------------------------------
// mem_wb_writeback
// MEM/WB pipeline stage that feeds the register-file write port directly.
// It captures one memory-stage result and extends sub-word loads. It then
// selects link, load or ALU data and drives the register-file write controls.
// It also offers a forwarding tap and a saturating retired-instruction counter.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake (in_ready = !valid | !hold)
//   hold, flush         downstream stall / kill of the staged instruction
//   in_*                memory-stage fields captured on accept
//   wb_*                register-file write controls, qualified by retire
//   fwd_*               forwarding tap (valid while staged, not retire-gated)
//   wb_misalign         misaligned-load pulse on retire (write suppressed)
//   retired_cnt         saturating count of retired instructions
// -----------------------------------------------------------------------------
module mem_wb_writeback #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              hold,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_pc_plus4,
  input  logic [REG_AW-1:0] in_dest,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic              in_jal,
  input  logic [1:0]        in_load_size,
  input  logic              in_load_signed,
  input  logic [1:0]        in_byte_off,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_write_addr,
  output logic [DATA_W-1:0] wb_write_data,
  output logic              wb_jal,
  output logic [DATA_W-1:0] wb_link_data,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic              wb_misalign,
  output logic [CNT_W-1:0]  retired_cnt
);

  logic              r_valid;
  logic [DATA_W-1:0] r_alu_result;
  logic [DATA_W-1:0] r_mem_data;
  logic [DATA_W-1:0] r_pc_plus4;
  logic [REG_AW-1:0] r_dest;
  logic              r_reg_write;
  logic              r_mem_to_reg;
  logic              r_jal;
  logic [1:0]        r_load_size;
  logic              r_load_signed;
  logic [1:0]        r_byte_off;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_retire;
  logic              w_misalign;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_ext;
  logic [DATA_W-1:0] w_data;
  logic [REG_AW-1:0] w_addr;
  logic              w_wr_cond;

  assign in_ready = !r_valid || !hold;
  assign w_retire = r_valid && !hold;

  // Stage register: flush beats hold and capture; the incoming beat is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid       <= 1'b0;
      r_alu_result  <= {DATA_W{1'b0}};
      r_mem_data    <= {DATA_W{1'b0}};
      r_pc_plus4    <= {DATA_W{1'b0}};
      r_dest        <= {REG_AW{1'b0}};
      r_reg_write   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_jal         <= 1'b0;
      r_load_size   <= 2'b00;
      r_load_signed <= 1'b0;
      r_byte_off    <= 2'b00;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (in_ready) begin
      if (in_valid) begin
        r_valid       <= 1'b1;
        r_alu_result  <= in_alu_result;
        r_mem_data    <= in_mem_data;
        r_pc_plus4    <= in_pc_plus4;
        r_dest        <= in_dest;
        r_reg_write   <= in_reg_write;
        r_mem_to_reg  <= in_mem_to_reg;
        r_jal         <= in_jal;
        r_load_size   <= in_load_size;
        r_load_signed <= in_load_signed;
        r_byte_off    <= in_byte_off;
      end else begin
        r_valid <= 1'b0;
      end
    end else begin
      r_valid <= r_valid;
    end
  end

  // Retire counter; a retiring instruction counts even if flushed on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_retire && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Little-endian lane pick and extension of sub-word loads.
  always_comb begin
    w_byte     = 8'h00;
    w_half     = 16'h0000;
    w_ext      = r_mem_data;
    w_misalign = 1'b0;
    case (r_byte_off)
      2'b00:   w_byte = r_mem_data[7:0];
      2'b01:   w_byte = r_mem_data[15:8];
      2'b10:   w_byte = r_mem_data[23:16];
      2'b11:   w_byte = r_mem_data[31:24];
      default: w_byte = 8'h00;
    endcase
    if (r_byte_off[1]) begin
      w_half = r_mem_data[31:16];
    end else begin
      w_half = r_mem_data[15:0];
    end
    case (r_load_size)
      2'b00: begin
        w_ext = {{(DATA_W-8){r_load_signed & w_byte[7]}}, w_byte};
      end
      2'b01: begin
        w_ext      = {{(DATA_W-16){r_load_signed & w_half[15]}}, w_half};
        w_misalign = r_byte_off[0];
      end
      default: begin
        // Reserved size 2'b11 behaves as a word load.
        w_ext      = r_mem_data;
        w_misalign = (r_byte_off != 2'b00);
      end
    endcase
  end

  // Write data/address select and the unretired write condition.
  always_comb begin
    w_data    = r_alu_result;
    w_addr    = r_dest;
    w_wr_cond = 1'b0;
    if (r_jal) begin
      w_data = r_pc_plus4;
      w_addr = REG_AW'(LINK_REG);
    end else if (r_mem_to_reg) begin
      w_data = w_ext;
    end else begin
      w_data = r_alu_result;
    end
    // Misalignment only matters for loads; ALU results ignore the byte offset.
    w_wr_cond = r_jal ||
                (r_reg_write && (r_dest != {REG_AW{1'b0}}) && !(r_mem_to_reg && w_misalign));
  end

  assign wb_reg_write  = w_retire && w_wr_cond;
  assign wb_write_addr = w_addr;
  assign wb_write_data = w_data;
  assign wb_jal        = w_retire && r_jal;
  assign wb_link_data  = r_jal ? r_pc_plus4 : {DATA_W{1'b0}};
  assign wb_misalign   = w_retire && r_mem_to_reg && r_reg_write && w_misalign;
  assign fwd_valid     = r_valid && w_wr_cond;
  assign fwd_addr      = w_addr;
  assign fwd_data      = w_data;
  assign retired_cnt   = r_cnt;

endmodule

// File: tb/tb_mem_wb_writeback.sv
module tb_mem_wb_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, hold, flush;
  logic [31:0] in_alu_result, in_mem_data, in_pc_plus4;
  logic [4:0]  in_dest;
  logic        in_reg_write, in_mem_to_reg, in_jal, in_load_signed;
  logic [1:0]  in_load_size, in_byte_off;
  logic        wb_reg_write, wb_jal, fwd_valid, wb_misalign;
  logic [4:0]  wb_write_addr, fwd_addr;
  logic [31:0] wb_write_data, wb_link_data, fwd_data;
  logic [15:0] retired_cnt;

  mem_wb_writeback dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .hold(hold), .flush(flush), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_pc_plus4(in_pc_plus4), .in_dest(in_dest),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_jal(in_jal),
    .in_load_size(in_load_size), .in_load_signed(in_load_signed),
    .in_byte_off(in_byte_off), .wb_reg_write(wb_reg_write),
    .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
    .wb_jal(wb_jal), .wb_link_data(wb_link_data), .fwd_valid(fwd_valid),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .wb_misalign(wb_misalign),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        jal;
    logic        mis;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] link;
  } exp_t;

  exp_t q[$];
  exp_t m_item;
  bit   m_valid  = 1'b0;
  bit   m_pushed = 1'b0;
  int   exp_cnt  = 0;
  int   n_cmp    = 0;
  int   n_bad    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: expected writeback result derived from the instruction fields.
  function automatic exp_t ref_model();
    exp_t   e;
    longint raw;
    int     bits;
    bit     misal;
    case (in_load_size)
      2'd0: begin raw = longint'((in_mem_data >> (8 * in_byte_off)) & 32'hFF); bits = 8; end
      2'd1: begin raw = longint'((in_mem_data >> (16 * in_byte_off[1])) & 32'hFFFF); bits = 16; end
      default: begin raw = longint'(in_mem_data); bits = 32; end
    endcase
    misal = (in_load_size == 2'd1) ? (in_byte_off[0] == 1'b1)
          : (in_load_size == 2'd0) ? 1'b0 : (in_byte_off != 2'd0);
    if (in_load_signed && bits < 32 && raw >= (64'sd1 <<< (bits - 1)))
      raw = raw - (64'sd1 <<< bits);
    e.jal  = in_jal;
    e.addr = in_jal ? 5'd31 : in_dest;
    e.data = in_jal ? in_pc_plus4 : (in_mem_to_reg ? raw[31:0] : in_alu_result);
    e.link = in_jal ? in_pc_plus4 : 32'd0;
    e.mis  = in_mem_to_reg && in_reg_write && misal;
    e.we   = in_jal || (in_reg_write && in_dest != 5'd0 && !(in_mem_to_reg && misal));
    return e;
  endfunction

  // Model one clock edge from the inputs that were present at that edge.
  task automatic model_edge();
    bit rdy;
    rdy = !m_valid || !hold;
    if (m_valid && !hold) begin
      exp_cnt  = (exp_cnt < 65535) ? exp_cnt + 1 : 65535;
      m_pushed = 1'b0;
    end
    if (flush) begin
      if (m_pushed) void'(q.pop_back());
      m_valid  = 1'b0;
      m_pushed = 1'b0;
    end else if (rdy) begin
      if (in_valid) begin
        m_item   = ref_model();
        m_valid  = 1'b1;
        m_pushed = m_item.we || m_item.mis;
        if (m_pushed) q.push_back(m_item);
      end else begin
        m_valid  = 1'b0;
        m_pushed = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic beat(input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
                      input logic [4:0] dest, input logic rw, input logic mtr, input logic jal,
                      input logic [1:0] size, input logic sgn, input logic [1:0] off);
    in_valid = 1'b1; in_alu_result = alu; in_mem_data = mem; in_pc_plus4 = pc;
    in_dest = dest; in_reg_write = rw; in_mem_to_reg = mtr; in_jal = jal;
    in_load_size = size; in_load_signed = sgn; in_byte_off = off;
  endtask

  // Issue one beat, then look at the stage on the following falling edge.
  task automatic one(input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
                     input logic [4:0] dest, input logic rw, input logic mtr, input logic jal,
                     input logic [1:0] size, input logic sgn, input logic [1:0] off);
    beat(alu, mem, pc, dest, rw, mtr, jal, size, sgn, off);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: pop the expected record whenever the stage presents a strobe.
  always @(negedge clk) begin
    exp_t e;
    chk("retired_cnt", {48'd0, retired_cnt}, exp_cnt);
    chk("in_ready", {63'd0, in_ready}, {63'd0, (!m_valid || !hold)});
    chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, (m_valid && m_item.we)});
    if (wb_reg_write || wb_misalign) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", {62'd0, wb_reg_write, wb_misalign}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("wb_reg_write", {63'd0, wb_reg_write}, {63'd0, e.we});
        chk("wb_misalign", {63'd0, wb_misalign}, {63'd0, e.mis});
        chk("wb_jal", {63'd0, wb_jal}, {63'd0, e.jal});
        chk("wb_write_addr", {59'd0, wb_write_addr}, {59'd0, e.addr});
        chk("wb_write_data", {32'd0, wb_write_data}, {32'd0, e.data});
        chk("wb_link_data", {32'd0, wb_link_data}, {32'd0, e.link});
        chk("fwd_addr", {59'd0, fwd_addr}, {59'd0, e.addr});
        chk("fwd_data", {32'd0, fwd_data}, {32'd0, e.data});
      end
    end
  end

  initial begin
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
    beat(32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0);
    in_valid = 1'b0;
    #12;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_outs", {wb_reg_write, wb_jal, fwd_valid, wb_misalign, wb_write_addr, fwd_addr},
        64'd0);
    chk("rst_data", {wb_write_data, wb_link_data}, 64'd0);
    chk("rst_cnt", {48'd0, retired_cnt}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // ALU write to r8
    one(32'h0000_1234, 32'd0, 32'd0, 5'd8, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0);
    chk("alu_we", {63'd0, wb_reg_write}, 64'd1);
    chk("alu_addr", {59'd0, wb_write_addr}, 64'd8);
    chk("alu_data", {32'd0, wb_write_data}, 64'h1234);
    chk("alu_cnt", {48'd0, retired_cnt}, 64'd0);
    cyc();
    chk("alu_cnt_after", {48'd0, retired_cnt}, 64'd1);

    // Loads from 80FF_7F81
    one(32'd0, 32'h80FF_7F81, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0);
    chk("lb_off0", {32'd0, wb_write_data}, 64'hFFFF_FF81);
    one(32'd0, 32'h80FF_7F81, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd3);
    chk("lbu_off3", {32'd0, wb_write_data}, 64'h0000_0080);
    one(32'd0, 32'h80FF_7F81, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 2'd2);
    chk("lh_off2", {32'd0, wb_write_data}, 64'hFFFF_80FF);
    one(32'd0, 32'h80FF_7F81, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 2'd1);
    chk("lw_off1_we", {63'd0, wb_reg_write}, 64'd0);
    chk("lw_off1_mis", {63'd0, wb_misalign}, 64'd1);

    // JAL with dest 0 still links to r31
    one(32'd0, 32'd0, 32'h0040_0010, 5'd0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0);
    chk("jal_we", {62'd0, wb_reg_write, wb_jal}, 64'd3);
    chk("jal_addr", {59'd0, wb_write_addr}, 64'd31);
    chk("jal_data", {wb_write_data, wb_link_data}, 64'h0040_0010_0040_0010);

    // r0 write suppressed
    one(32'd5, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0);
    chk("r0_we", {62'd0, wb_reg_write, fwd_valid}, 64'd0);

    // Hold for three cycles, then release
    beat(32'hA5A5_0001, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0);
    cyc();
    in_valid = 1'b0; hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_no_strobe", {62'd0, in_ready, wb_reg_write}, 64'd0);
      cyc();
    end
    hold = 1'b0;
    @(negedge clk);
    chk("release_strobe", {63'd0, wb_reg_write}, 64'd1);
    cyc();

    // Flush together with an incoming beat
    beat(32'd77, 32'd0, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0);
    flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_drop", {62'd0, wb_reg_write, fwd_valid}, 64'd0);

    // Reset asserted while an instruction is held
    beat(32'd99, 32'd0, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0);
    cyc();
    in_valid = 1'b0; hold = 1'b1;
    cyc();
    rst_n = 1'b0;
    m_valid = 1'b0; m_pushed = 1'b0; exp_cnt = 0; q.delete();
    #1;
    chk("rst_mid_outs", {wb_reg_write, wb_jal, fwd_valid, wb_misalign, in_ready,
                         wb_write_addr, retired_cnt}, 64'd1 << 21);
    chk("rst_mid_data", {wb_write_data, wb_link_data}, 64'd0);
    hold = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      logic        mtr;
      logic [1:0]  sz, off;
      mtr = 1'($urandom_range(0, 1));
      sz  = mtr ? 2'($urandom_range(0, 3)) : 2'd2;
      off = mtr ? 2'($urandom_range(0, 3)) : 2'd0;
      beat($urandom, $urandom, $urandom, 5'($urandom_range(0, 31) & ((i % 5 == 0) ? 0 : 31)),
           1'($urandom_range(0, 3) != 0), mtr, 1'($urandom_range(0, 7) == 0),
           sz, 1'($urandom_range(0, 1)), off);
      in_valid = 1'($urandom_range(0, 3) != 0);
      hold     = 1'($urandom_range(0, 3) == 0);
      flush    = 1'($urandom_range(0, 15) == 0);
      cyc();
    end
    hold = 1'b0; flush = 1'b0;

    // Saturation: stream non-writing instructions past the counter maximum
    beat(32'd0, 32'd0, 32'd0, 5'd1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0);
    for (int i = 0; i < 65600; i++) cyc();
    @(negedge clk);
    chk("cnt_saturated", {48'd0, retired_cnt}, 64'hFFFF);
    cyc();
    in_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("cnt_still_sat", {48'd0, retired_cnt}, 64'hFFFF);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
